// File: rtl/counter_pkg.sv
// Shared constants and sizing helper for the generic mod_counter family.
package counter_pkg;

  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // Ceiling log2; returns 0 for values of 0 or 1.
  function automatic int clog2(input longint unsigned v);
    longint unsigned x;
    int r;
    x = 1;
    r = 0;
    while (x < v) begin
      x = x << 1;
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Enable divider: tick on every PRESCALE-th enabled cycle, combinational from the phase register.
// No backpressure; clr (load) and reset return the phase to 0 on the next edge.
module counter_prescaler
  import counter_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int PS_W = (clog2(PRESCALE) < 1) ? 1 : clog2(PRESCALE);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] phase_q;
  logic [PS_W-1:0] phase_d;

  assign tick = en && (phase_q == PS_LAST);

  always_comb begin
    phase_d = phase_q;
    if (clr) begin
      phase_d = '0;
    end else if (en) begin
      phase_d = tick ? '0 : phase_q + PS_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/mod_counter.sv
// Generic up/down modulo counter with load, wrap/saturate, tc, wrap pulse and sticky ovf; optional COUNTER_PRESCALE_EN divider.
// Count updates one edge after an enabled step; no backpressure, en qualifies every cycle.
module mod_counter
  import counter_pkg::*;
#(
  parameter int unsigned     WIDTH    = 4,
  parameter longint unsigned MODULUS  = 16,
  parameter int              SATURATE = 0,
  parameter int unsigned     PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  if (WIDTH < 1 || WIDTH > 32 || MODULUS < 2 || MODULUS > (64'd1 << WIDTH) ||
      (SATURATE != MODE_WRAP && SATURATE != MODE_SAT) ||
      PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_params
    $error("mod_counter: illegal parameter combination");
  end

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic             step;
  logic             boundary;

`ifdef COUNTER_PRESCALE_EN
  counter_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk    (clk),
    .reset_n(reset_n),
    .en     (en),
    .clr    (load),
    .tick   (step)
  );
`else
  assign step = en;
`endif

  assign boundary = (up_dn == DIR_UP) ? (count_q == MAX_VAL) : (count_q == '0);
  assign tc       = step && !load && boundary;

  assign count = count_q;
  assign wrap  = wrap_q;
  assign ovf   = ovf_q;

  // Next values are picked explicitly so a non-power-of-2 MODULUS never relies on WIDTH rollover.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    ovf_d   = ovf_q && !clr_ovf;
    if (load) begin
      count_d = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    end else if (step) begin
      if (boundary) begin
        wrap_d = 1'b1;
        ovf_d  = 1'b1;
        if (SATURATE != MODE_SAT) begin
          count_d = (up_dn == DIR_UP) ? '0 : MAX_VAL;
        end
      end else begin
        count_d = (up_dn == DIR_UP) ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: doc/mod_counter.md
Name: mod_counter

Overview:
Parametrised successor to the team's free-running 4-bit counter. Generalised width and modulus, up/down direction, synchronous parallel load, wrap or saturate mode, terminal-count and wrap indications, sticky overflow flag. Used as the generic timing/event counter in datapath and control blocks; replaces fixed-width counters.

Parameters:
WIDTH, 4, count register width in bits; legal range 1..32.
MODULUS, 16, count range is 0..MODULUS-1; legal range 2..2^WIDTH.
SATURATE, 0, 0 = wrap at the boundary, 1 = hold at the boundary.
PRESCALE, 1, enable divider ratio; used only when COUNTER_PRESCALE_EN is defined; legal range 1..65535.

Ports:
clk  in  1  rising-edge clock; the only clock.
reset_n  in  1  synchronous, active-low reset.
en  in  1  count enable, qualified per cycle.
up_dn  in  1  1 = count up, 0 = count down; sampled each enabled cycle.
load  in  1  synchronous parallel load strobe.
load_val  in  WIDTH  load value.
clr_ovf  in  1  clears the sticky overflow flag.
count  out  WIDTH  current count, registered.
tc  out  1  terminal count, combinational: the next enabled step hits the boundary.
wrap  out  1  registered one-cycle pulse; the count wrapped or saturated on the last edge.
ovf  out  1  sticky flag: a wrap or saturation has occurred since last clear.

Behaviour:
- Reset: while reset_n = 0 at a rising edge, count = 0, wrap = 0, ovf = 0, prescaler = 0. Reset overrides every other input. Assertion mid-count clears on that edge with no partial update.
- Priority at each edge: reset_n low > load > counting (en) > hold.
- Load: count <= load_val when load_val < MODULUS, else count <= MODULUS-1 (clamp). A load cycle ignores en, sets wrap = 0 and leaves ovf unchanged.
- Up step (en=1, up_dn=1): if count < MODULUS-1, count <= count+1. At count = MODULUS-1: SATURATE=0 gives count <= 0; SATURATE=1 holds the count. Either case gives wrap <= 1 and ovf <= 1.
- Down step (en=1, up_dn=0): if count > 0, count <= count-1. At count = 0: SATURATE=0 gives count <= MODULUS-1; SATURATE=1 holds the count. Either case gives wrap <= 1 and ovf <= 1.
- Any edge without a boundary event gives wrap <= 0. The wrap pulse lasts exactly one cycle per event. Back-to-back boundary events in saturate mode hold wrap high.
- tc = en & ((up_dn & count==MODULUS-1) | (~up_dn & count==0)), further gated by the prescaler tick when prescale is built in. tc is 0 when load = 1.
- ovf: clr_ovf = 1 clears it. A boundary event in the same cycle as clr_ovf wins, so ovf stays 1.
- Arithmetic is modulo-free: the next value is always selected explicitly and never relies on natural WIDTH overflow, so non-power-of-2 MODULUS is exact.
- Direction can change on any cycle. Latency: count reflects the step one edge after the enabled cycle.
- Illegal parameters (MODULUS > 2^WIDTH, MODULUS < 2) fail elaboration through a generate-time check.

Optional Feature:
COUNTER_PRESCALE_EN.
- Defined: an internal prescaler counts enabled cycles 0..PRESCALE-1. The main counter steps only on the enabled cycle where the prescaler equals PRESCALE-1, and the prescaler then returns to 0. Load and reset clear the prescaler. PRESCALE = 1 is behaviourally identical to the undefined build.
- Undefined: no prescaler logic is instantiated, PRESCALE is ignored, and every en cycle is a step.

Decomposition:
- Shared package counter_pkg holds: direction constants DIR_DOWN=0 and DIR_UP=1; mode constants MODE_WRAP=0 and MODE_SAT=1; a clog2 helper function for prescaler sizing.
- One sub-module, counter_prescaler (inputs clk, reset_n, en, clr; output tick), instantiated only under COUNTER_PRESCALE_EN.
- The main next-state logic stays in mod_counter.

Test Plan:
- WIDTH=4, MODULUS=10, wrap mode; release reset, en=1, up for 12 cycles -> count 1..9,0,1,2; wrap high only for the cycle after 9->0; ovf=1 from then on; tc=1 while count=9.
- Same configuration, down from count 0 with en=1 -> count 9,8,...; wrap pulse on 0->9; clr_ovf pulse clears ovf; clr_ovf coincident with a boundary event -> ovf stays 1.
- load_val=12 with MODULUS=10 -> count=9; load=1 and en=1 together -> load wins; up_dn toggled every cycle from 5 -> count alternates 6,5,6.
- SATURATE=1, MODULUS=16; count up from 14 for 4 cycles -> 15,15,15,15; wrap high on each held cycle; down from 0 -> holds 0.
- Reset mid-count at 7 with load=1 and en=1 asserted -> count=0, wrap=0, ovf=0 on that edge; reset_n=1 -> counting resumes the next edge.
- COUNTER_PRESCALE_EN defined, PRESCALE=3, en continuous -> count increments every 3rd cycle; en gaps stall the prescaler; load clears the prescaler phase.
